// File: rtl/arisc_cpu.sv
// Multi-cycle 8-bit RISC core: IDLE/FETCH/EXEC/LOAD sequencer in front of synchronous instruction and data RAMs.
// Optional build macro ARISC_MUL_EN turns opcode 15 into MUL; otherwise opcode 15 is a NOP.
module arisc_cpu #(
  parameter int NUM_GPR = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        idle,
  output logic [7:0]  iram_addr,
  input  logic [15:0] iram_dout,
  output logic [7:0]  dram_addr,
  output logic [7:0]  dram_din,
  input  logic [7:0]  dram_dout,
  output logic        dram_write
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  localparam logic [3:0] OP_HALT = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_BEQZ = 4'd13;
  localparam logic [3:0] OP_BNEZ = 4'd14;
  localparam logic [3:0] OP_X15  = 4'd15;

  localparam logic [4:0] GPR_LIM = 5'(NUM_GPR);

  logic [1:0] state;
  logic [7:0] pc;
  logic [3:0] ld_rd;
  // Entries at or above NUM_GPR, and R0, are never written, so they stay at their reset value of 0.
  logic [7:0] regs [16];

  logic [3:0] op, rd, ra, rb;
  logic [7:0] imm8, va, vb, vd;
  logic [7:0] alu_res, pc_next;
  logic       wb_en, exec;

  assign op   = iram_dout[3:0];
  assign rd   = iram_dout[7:4];
  assign ra   = iram_dout[11:8];
  assign rb   = iram_dout[15:12];
  assign imm8 = {ra, rb};
  assign va   = regs[ra];
  assign vb   = regs[rb];
  assign vd   = regs[rd];

  function automatic logic writable(input logic [3:0] idx);
    return (idx != 4'd0) && ({1'b0, idx} < GPR_LIM);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    alu_res = '0;
    wb_en   = 1'b0;
    pc_next = pc + 8'd1;
    unique case (op)
      OP_ADD:  begin alu_res = va + vb;          wb_en = 1'b1; end
      OP_SUB:  begin alu_res = va - vb;          wb_en = 1'b1; end
      OP_AND:  begin alu_res = va & vb;          wb_en = 1'b1; end
      OP_OR:   begin alu_res = va | vb;          wb_en = 1'b1; end
      OP_XOR:  begin alu_res = va ^ vb;          wb_en = 1'b1; end
      OP_SHL:  begin alu_res = va << vb[2:0];    wb_en = 1'b1; end
      OP_SHR:  begin alu_res = va >> vb[2:0];    wb_en = 1'b1; end
      OP_LDI:  begin alu_res = imm8;             wb_en = 1'b1; end
      OP_ADDI: begin alu_res = vd + imm8;        wb_en = 1'b1; end
      OP_JMP:  pc_next = imm8;
      OP_BEQZ: if (vd == 8'd0) pc_next = imm8;
      OP_BNEZ: if (vd != 8'd0) pc_next = imm8;
`ifdef ARISC_MUL_EN
      OP_X15:  begin alu_res = va * vb;          wb_en = 1'b1; end
`else
      OP_X15:  ;
`endif
      default: ;
    endcase
  end

  // Data-port outputs are decoded from the registered state, so reset drops a store strobe at once.
  assign exec       = (state == S_EXEC);
  assign idle       = (state == S_IDLE);
  assign iram_addr  = pc;
  assign dram_write = exec && (op == OP_ST);
  assign dram_addr  = (exec && (op == OP_LD || op == OP_ST)) ? va : 8'd0;
  assign dram_din   = (exec && op == OP_ST) ? vd : 8'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      pc    <= 8'd0;
      ld_rd <= 4'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else begin
      // NOTE: all state here updates with <= so every read sees the pre-edge value.
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= 8'd0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          if (op == OP_HALT) begin
            state <= S_IDLE;
          end else if (op == OP_LD) begin
            ld_rd <= rd;
            state <= S_LOAD;
          end else begin
            if (wb_en && writable(rd)) regs[rd] <= alu_res;
            pc    <= pc_next;
            state <= S_FETCH;
          end
        end
        S_LOAD: begin
          if (writable(ld_rd)) regs[ld_rd] <= dram_dout;
          pc    <= pc + 8'd1;
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arisc_cpu.sv
// Self-checking bench for arisc_cpu: directed programs plus random straight-line programs
// compared against an instruction-level interpreter of the ISA.
module tb_arisc_cpu;
  localparam int NUM_GPR = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        idle;
  logic [7:0]  iram_addr, dram_addr, dram_din, dram_dout;
  logic [15:0] iram_dout;
  logic        dram_write;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  logic [7:0]  m_dmem [256];
  logic [7:0]  m_regs [16];
  logic [15:0] prog [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  arisc_cpu #(.NUM_GPR(NUM_GPR)) dut (
    .clk(clk), .rstn(rstn), .start(start), .idle(idle),
    .iram_addr(iram_addr), .iram_dout(iram_dout),
    .dram_addr(dram_addr), .dram_din(dram_din), .dram_dout(dram_dout),
    .dram_write(dram_write)
  );

  // Synchronous-read RAMs with one cycle of latency.
  always @(posedge clk) begin
    iram_dout <= imem[iram_addr];
    dram_dout <= dmem[dram_addr];
    if (dram_write) dmem[dram_addr] <= dram_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
    return {4'(rb), 4'(ra), 4'(rd), 4'(op)};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rd, input int imm);
    return enc(op, rd, imm / 16, imm % 16);
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++) imem[i] = (i < prog.size()) ? prog[i] : 16'h0000;
  endtask

  function automatic int mr(input int idx);
    return (idx == 0 || idx >= NUM_GPR) ? 0 : int'(m_regs[idx]);
  endfunction

  task automatic mw(input int idx, input int v);
    if (idx != 0 && idx < NUM_GPR) m_regs[idx] = 8'(v % 256);
  endtask

  // Instruction-level interpreter: architectural effect and cycle cost of each instruction.
  task automatic model_run(output int cyc);
    int pc, op, rd, ra, rb, imm, a, b, d, nxt;
    bit done;
    pc = 0; cyc = 0; done = 0;
    for (int step = 0; step < 2000 && !done; step++) begin
      op = int'(imem[pc][3:0]);   rd = int'(imem[pc][7:4]);
      ra = int'(imem[pc][11:8]);  rb = int'(imem[pc][15:12]);
      imm = ra * 16 + rb;
      a = mr(ra); b = mr(rb); d = mr(rd);
      nxt = (pc + 1) % 256;
      cyc += 2;
      case (op)
        0:  done = 1;
        1:  mw(rd, a + b);
        2:  mw(rd, a - b + 256);
        3:  mw(rd, a & b);
        4:  mw(rd, a | b);
        5:  mw(rd, a ^ b);
        6:  mw(rd, a * (2 ** (b % 8)));
        7:  mw(rd, a / (2 ** (b % 8)));
        8:  mw(rd, imm);
        9:  mw(rd, d + imm);
        10: begin mw(rd, int'(m_dmem[a])); cyc += 1; end
        11: m_dmem[a] = 8'(d);
        12: nxt = imm;
        13: if (d == 0) nxt = imm;
        14: if (d != 0) nxt = imm;
`ifdef ARISC_MUL_EN
        15: mw(rd, a * b);
`endif
        default: ;
      endcase
      if (!done) pc = nxt;
    end
  endtask

  task automatic run(input string tag, input bit poke_halt);
    int exp_cyc, cyc;
    load_prog();
    model_run(exp_cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    check({tag, ":idle_low"}, 32'(idle), 32'd0);
    while (cyc < 3000) begin
      if (poke_halt && cyc == exp_cyc - 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (idle) break;
    end
    check({tag, ":cycles"}, 32'(cyc), 32'(exp_cyc));
    if (poke_halt) begin
      repeat (2) @(negedge clk);
      check({tag, ":start_at_halt_ignored"}, 32'(idle), 32'd1);
    end
    for (int i = 0; i < 256; i++)
      check($sformatf("%s:dram[%0d]", tag, i), 32'(dmem[i]), 32'(m_dmem[i]));
  endtask

  task automatic gen_random(input int n);
    int op, tgt;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(1, 15);
      if (op >= 12 && op <= 14) begin
        tgt = i + 1 + $urandom_range(0, 3);
        if (tgt > n) tgt = n;
        prog.push_back(enc_i(op, $urandom_range(0, 15), tgt));
      end else begin
        prog.push_back(enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)));
      end
    end
    for (int r = 1; r <= 6; r++) begin
      prog.push_back(enc_i(8, 7, 240 + r));
      prog.push_back(enc(11, r, 7, 0));
    end
    prog.push_back(16'h0000);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'($urandom);
      m_dmem[i] = dmem[i];
      imem[i] = 16'h0000;
    end
    for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;

    #1;
    check("rst:idle", 32'(idle), 32'd1);
    check("rst:dram_write", 32'(dram_write), 32'd0);
    check("rst:iram_addr", 32'(iram_addr), 32'd0);
    check("rst:dram_addr", 32'(dram_addr), 32'd0);
    check("rst:dram_din", 32'(dram_din), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst:idle", 32'(idle), 32'd1);
      check("post_rst:iram_addr", 32'(iram_addr), 32'd0);
      check("post_rst:dram_write", 32'(dram_write), 32'd0);
    end

    prog = '{enc_i(8, 1, 5), enc_i(8, 2, 7), enc(1, 3, 1, 2), enc_i(8, 4, 8'h10),
             enc(11, 3, 4, 0), 16'h0000};
    run("basic", 1'b1);
    check("basic:dram[0x10]", 32'(dmem[8'h10]), 32'd12);

    prog = '{enc_i(8, 1, 5), enc_i(8, 2, 0), enc(1, 2, 2, 1), enc_i(9, 1, 8'hFF),
             enc_i(14, 1, 2), enc_i(8, 3, 0), enc(11, 2, 3, 0), 16'h0000};
    run("triangle", 1'b0);
    check("triangle:dram[0]", 32'(dmem[0]), 32'd15);

    prog = '{enc_i(8, 1, 8'hF0), enc_i(9, 1, 8'h20), enc_i(8, 2, 8'h81), enc_i(8, 3, 1),
             enc(6, 4, 2, 3), enc_i(8, 5, 3), enc_i(8, 6, 5), enc(2, 7, 5, 6),
             enc_i(8, 2, 8'h40), enc(11, 1, 2, 0), enc_i(8, 2, 8'h41), enc(11, 4, 2, 0),
             enc_i(8, 2, 8'h42), enc(11, 7, 2, 0), 16'h0000};
    run("wrap_shift", 1'b0);
    check("wrap:addi", 32'(dmem[8'h40]), 32'h10);
    check("wrap:shl", 32'(dmem[8'h41]), 32'h02);
    check("wrap:sub", 32'(dmem[8'h42]), 32'hFE);

    dmem[8'h51] = 8'hEE; m_dmem[8'h51] = 8'hEE;
    dmem[8'h52] = 8'hEE; m_dmem[8'h52] = 8'hEE;
    prog = '{enc_i(8, 1, 8'hA5), enc_i(8, 2, 8'h20), enc(11, 1, 2, 0), enc(10, 5, 2, 0),
             enc_i(8, 0, 8'h33), enc_i(8, 9, 8'h44), enc_i(8, 2, 8'h50), enc(11, 5, 2, 0),
             enc_i(8, 2, 8'h51), enc(11, 0, 2, 0), enc_i(8, 2, 8'h52), enc(11, 9, 2, 0),
             16'h0000};
    run("ld_bounds", 1'b0);
    check("ld:r5", 32'(dmem[8'h50]), 32'hA5);
    check("bounds:r0", 32'(dmem[8'h51]), 32'h00);
    check("bounds:r9", 32'(dmem[8'h52]), 32'h00);

    for (int k = 0; k < 12; k++) begin
      gen_random(24);
      run($sformatf("rand%0d", k), 1'b0);
    end

    dmem[8'h30] = 8'h5A; m_dmem[8'h30] = 8'h5A;
    prog = '{enc_i(8, 4, 8'h30), enc_i(8, 3, 8'h77), enc(11, 3, 4, 0), 16'h0000};
    load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (!dram_write && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("midrst:st_reached", 32'(dram_write), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst:dram_write", 32'(dram_write), 32'd0);
    check("midrst:idle", 32'(idle), 32'd1);
    @(posedge clk); #1;
    check("midrst:dram_unchanged", 32'(dmem[8'h30]), 32'h5A);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;

    for (int k = 0; k < 4; k++) begin
      gen_random(20);
      run($sformatf("post_rst_rand%0d", k), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
